// File: rtl/cla_seq_pkg.sv
// Shared definitions for the sequential carry-lookahead adder: FSM state encoding,
// nibble size and the index-width helper.
package cla_seq_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Plain-vector aliases so state registers stay ordinary logic vectors.
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for cla_seq_adder.
// The sub field exists only when CLA_SEQ_SUB_EN is defined.
interface cla_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef CLA_SEQ_SUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/cla_seq_adder_cla4_slice.sv
// 4-bit combinational carry-lookahead slice; all carries are computed directly
// from generate/propagate terms rather than rippled.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit CLA slice per nibble, LSB first.
// Define CLA_SEQ_SUB_EN to add the sub port (a - b via inverted b and carry-in 1).
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  cla_seq_adder_if.slave   bus,
  output logic             busy
);

  localparam int NSLICE = WIDTH / NIBBLE;
  localparam int IW     = idx_width(NSLICE);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [3:0]       slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;

  cla4_slice u_slice (
    .a  (a_sh_q[3:0]),
    .b  (b_sh_q[3:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

`ifdef CLA_SEQ_SUB_EN
  assign b_cap = bus.sub ? ~bus.b : bus.b;
  assign c_cap = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_cap = bus.b;
  assign c_cap = bus.cin;
`endif

  // NOTE: every always_comb output gets a default (hold) first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = b_cap;
          carry_d = c_cap;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift form keeps WIDTH == 4 legal (no empty part-select).
        sum_sh_d = (sum_sh_q >> NIBBLE) | (WIDTH'(slice_s) << (WIDTH - NIBBLE));
        a_sh_d   = a_sh_q >> NIBBLE;
        b_sh_d   = b_sh_q >> NIBBLE;
        carry_d  = slice_co;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IW'(NSLICE - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
    end
  end

  // Handshake outputs decode state only; rst gates in_ready while asserted.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign busy          = (state_q == RUN) || (state_q == DONE);
  assign bus.sum       = sum_sh_q;
  assign bus.cout      = carry_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder (WIDTH=16).
module tb_cla_seq_adder;

  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  logic busy;
  int   tests;
  int   fails;

  cla_seq_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef CLA_SEQ_SUB_EN
    bus.sub = sub;
`else
    if (sub) $error("FAIL drive: sub requested without CLA_SEQ_SUB_EN");
`endif
  endtask

  // Presents operands for one accept edge; returns at the negedge after acceptance.
  task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, 32'(n < 20), 32'd1);
    drive(a, b, cin, sub);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Counts cycles since the accept edge until out_valid, then checks the result.
  task automatic wait_done(input string tag, input logic [15:0] exp_sum, input logic exp_cout);
    int cnt;
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'd4);
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] exp_sum, input logic exp_cout);
    start_op(tag, a, b, cin, sub);
    wait_done(tag, exp_sum, exp_cout);
    release_out();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(16'h0, 16'h0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_op("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("cin_wrap", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    run_op("msb_wrap", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Stall in DONE with a competing operand request held on the input.
    start_op("stall", 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    wait_done("stall", 16'hFFFF, 1'b0);
    drive(16'h0001, 16'h0002, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_sum", 32'(bus.sum), 32'hFFFF);
      check("stall_cout", 32'(bus.cout), 32'd0);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    // out_ready together with in_valid: only the output handshake completes.
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("sim_out_valid", 32'(bus.out_valid), 32'd0);
    check("sim_busy", 32'(busy), 32'd0);
    check("sim_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("sim_accept_busy", 32'(busy), 32'd1);
    wait_done("sim_next", 16'h0003, 1'b0);
    release_out();

    // Reset during the second RUN cycle discards the operation.
    start_op("abort", 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_recover_ready", 32'(bus.in_ready), 32'd1);
    check("abort_recover_busy", 32'(busy), 32'd0);
    run_op("after_abort", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0);

`ifdef CLA_SEQ_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub_pos", 16'h0009, 16'h0002, 1'b0, 1'b1, 16'h0007, 1'b1);
    run_op("sub0_add", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle WIDTH-bit adder controller that time-shares a single 4-bit carry-lookahead slice across successive nibbles of its operands. The slice's carry-out is registered between nibbles. Operands are accepted on a valid/ready input handshake, and the result is returned on a valid/ready output handshake. The block sits between an operand source (register file / sequencer) and a result consumer wherever a full-width parallel adder is too large.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 4
- NSLICE, WIDTH/4, derived nibble count; not user-overridable
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand transfer request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in to nibble 0
- sub  in  1  subtract select (present only with CLA_SEQ_SUB_EN)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered result
- cout  out  1  registered carry-out of top nibble
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b into operand shift registers; carry register <= cin; nibble index <= 0; go to RUN.
- RUN, once per cycle:
  - The slice adds a_sh[3:0] + b_sh[3:0] + carry.
  - sum_sh shifts right 4 bits, with the slice sum inserted at [WIDTH-1:WIDTH-4].
  - a_sh and b_sh shift right 4 bits.
  - carry <= slice cout; index++.
  - When index==NSLICE-1, that cycle completes the operation; go to DONE.
- DONE:
  - out_valid=1; sum=sum_sh; cout=carry; both held stable.
  - On out_ready: go to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored there and there is no queuing.
- in_ready=0 while rst is asserted.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). The carry chains exactly through all nibbles, including wrap to 0 with cout=1.
- sum/cout are meaningful only while out_valid=1. They may change during RUN.
- Reset value of every output: in_ready=0 (during rst), out_valid=0, sum=0, cout=0, busy=0. State=IDLE, carry=0, index=0.
- Reset mid-operation: the operation is discarded with no partial output. The first cycle after deassert is IDLE with in_ready=1.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The input is accepted no earlier than the following IDLE cycle.

## Timing
- Input handshake at edge E0 → RUN edges E1..E_NSLICE → out_valid visible after edge E_NSLICE. Latency is NSLICE cycles.
- The output handshake edge returns the block to IDLE. in_ready rises in the next cycle.
- Minimum initiation interval: NSLICE+2 cycles (WIDTH=16: 6 cycles).
- in_ready, out_valid and busy are decoded from state registers only. There is no combinational path from in_valid/out_ready to any output.
- The slice is purely combinational: one nibble per cycle with no internal pipelining.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - Port sub exists and is captured with the operands.
  - sub=1: b is inverted at capture and the carry register is initialised to 1; cin is ignored. Result = a − b mod 2^WIDTH; cout=1 means no borrow.
  - sub=0: addition, identical to the undefined case.
- CLA_SEQ_SUB_EN undefined: sub port absent; addition only.

## Structure
- Shared package cla_seq_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - NIBBLE=4 constant;
  - the index width function clog2(NSLICE), minimum 1.
- One sub-module, cla4_slice: 4-bit combinational carry-lookahead slice.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co.
  - Internally: per-bit p=a^b, g=a&b; carries c1..c4 by full lookahead equations; s=p^c.
- Top level holds the FSM, shift registers, carry register and index counter.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → out_valid exactly 4 cycles after accept; sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 → carry ripples through all slices; sum=0x0000, cout=1.
- a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. Then a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1.
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 → out_valid, sum and cout stable; in_ready=0; no second operand accepted. After release: in_ready=1 one cycle later.
- Assert rst for 1 cycle at the 2nd RUN cycle → out_valid=0, busy=0. After deassert, a=0x0F0F, b=0x00F1, cin=0 yields sum=0x1000, cout=0.
- With CLA_SEQ_SUB_EN: sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0. Then sub=1, a=0x0009, b=0x0002 → sum=0x0007, cout=1.
